wallace_mac_accumulator: RTL and testbench

//  Downstream consumer of the 16x16 Wallace tree multiplier. Registers operand pairs, instantiates the

---
 rtl/wallace_mac_accumulator.sv | 235 +++++++++++++++++++++++
 tb/tb_wallace_mac_accumulator.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mac_accumulator.sv
// Registered 16x16 Wallace-tree multiply feeding a block accumulator with valid/ready on both sides.
// Build option SATURATE_EN: clamp the block sum to all-ones on carry-out instead of wrapping.

module wallace_csa (
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    input  logic [31:0] i_z,
    output logic [31:0] o_s,
    output logic [31:0] o_c
);
    logic [31:0] w_maj;

    assign o_s   = i_x ^ i_y ^ i_z;
    assign w_maj = (i_x & i_y) | (i_x & i_z) | (i_y & i_z);
    assign o_c   = w_maj << 1;
endmodule

module wallace_mult_16x16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [31:0] o_p
);
    // Row-wise Wallace reduction: 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add.
    // Any carry past bit 31 is dropped; the true 16x16 product always fits in 32 bits.
    logic [31:0] w_l0 [16];
    logic [31:0] w_l1 [11];
    logic [31:0] w_l2 [8];
    logic [31:0] w_l3 [6];
    logic [31:0] w_l4 [4];
    logic [31:0] w_l5 [3];
    logic [31:0] w_l6 [2];

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_pp
            assign w_l0[g] = i_b[g] ? (32'(i_a) << g) : 32'd0;
        end

        for (g = 0; g < 5; g++) begin : g_l1
            wallace_csa u_csa (
                .i_x(w_l0[3*g]), .i_y(w_l0[3*g+1]), .i_z(w_l0[3*g+2]),
                .o_s(w_l1[2*g]), .o_c(w_l1[2*g+1])
            );
        end
        assign w_l1[10] = w_l0[15];

        for (g = 0; g < 3; g++) begin : g_l2
            wallace_csa u_csa (
                .i_x(w_l1[3*g]), .i_y(w_l1[3*g+1]), .i_z(w_l1[3*g+2]),
                .o_s(w_l2[2*g]), .o_c(w_l2[2*g+1])
            );
        end
        assign w_l2[6] = w_l1[9];
        assign w_l2[7] = w_l1[10];

        for (g = 0; g < 2; g++) begin : g_l3
            wallace_csa u_csa (
                .i_x(w_l2[3*g]), .i_y(w_l2[3*g+1]), .i_z(w_l2[3*g+2]),
                .o_s(w_l3[2*g]), .o_c(w_l3[2*g+1])
            );
        end
        assign w_l3[4] = w_l2[6];
        assign w_l3[5] = w_l2[7];

        for (g = 0; g < 2; g++) begin : g_l4
            wallace_csa u_csa (
                .i_x(w_l3[3*g]), .i_y(w_l3[3*g+1]), .i_z(w_l3[3*g+2]),
                .o_s(w_l4[2*g]), .o_c(w_l4[2*g+1])
            );
        end
    endgenerate

    wallace_csa u_csa_l5 (
        .i_x(w_l4[0]), .i_y(w_l4[1]), .i_z(w_l4[2]),
        .o_s(w_l5[0]), .o_c(w_l5[1])
    );
    assign w_l5[2] = w_l4[3];

    wallace_csa u_csa_l6 (
        .i_x(w_l5[0]), .i_y(w_l5[1]), .i_z(w_l5[2]),
        .o_s(w_l6[0]), .o_c(w_l6[1])
    );

    assign o_p = w_l6[0] + w_l6[1];
endmodule

module wallace_mac_accumulator #(
    parameter int ACC_W     = 40,
    parameter int BLOCK_LEN = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [15:0]      A,
    input  logic [15:0]      B,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [ACC_W-1:0] Acc,
    output logic             Overflow,
    output logic             Busy
);
    // state    | meaning
    // ST_ACCUM | accepting pairs, fewer than BLOCK_LEN taken so far
    // ST_DRAIN | block fully accepted, waiting for the last product to be added
    // ST_HOLD  | completed sum presented on Acc until the consumer takes it
    typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_HOLD} state_t;

    localparam int               CNT_W    = $clog2(BLOCK_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

    state_t r_state, w_state_nxt;

    logic [15:0]      r_a, r_b;
    logic             r_op_vld, r_op_last;
    logic [31:0]      w_prod, r_prod;
    logic             r_prod_vld, r_prod_last;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf_sticky;
    logic             r_sum_last;
    logic [CNT_W-1:0] r_count;
    logic [ACC_W-1:0] r_acc_out;
    logic             r_ovf_out;
    logic             r_out_valid;

    logic             w_in_ready, w_accept, w_load_out, w_out_fire;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;

    wallace_mult_16x16 u_mult (
        .i_a(r_a),
        .i_b(r_b),
        .o_p(w_prod)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_load_out  = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                w_in_ready = 1'b1;
                if (In_Valid && (r_count == LAST_IDX)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_sum_last) begin
                    w_load_out  = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (Out_Ready) w_state_nxt = ST_ACCUM;
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    assign In_Ready   = w_in_ready && !Rst;
    assign w_accept   = In_Valid && In_Ready;
    assign w_out_fire = r_out_valid && Out_Ready;

    assign w_sum     = {1'b0, r_acc} + {{(ACC_W-31){1'b0}}, r_prod};
    assign w_carry   = w_sum[ACC_W];
    assign w_ovf_nxt = r_ovf_sticky || w_carry;
`ifdef SATURATE_EN
    // Once clamped, the sum stays at all-ones until the block is handed off.
    assign w_acc_nxt = (w_carry || r_ovf_sticky) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= ST_ACCUM;
            r_a          <= '0;
            r_b          <= '0;
            r_op_vld     <= 1'b0;
            r_op_last    <= 1'b0;
            r_prod       <= '0;
            r_prod_vld   <= 1'b0;
            r_prod_last  <= 1'b0;
            r_acc        <= '0;
            r_ovf_sticky <= 1'b0;
            r_sum_last   <= 1'b0;
            r_count      <= '0;
            r_acc_out    <= '0;
            r_ovf_out    <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            r_op_vld  <= w_accept;
            r_op_last <= w_accept && (r_count == LAST_IDX);
            if (w_accept) begin
                r_a <= A;
                r_b <= B;
            end

            r_prod_vld  <= r_op_vld;
            r_prod_last <= r_op_vld && r_op_last;
            if (r_op_vld) r_prod <= w_prod;

            r_sum_last <= r_prod_vld && r_prod_last;

            // The pipeline is empty in HOLD, so clearing on the handshake never drops a product.
            if (w_out_fire) begin
                r_acc        <= '0;
                r_ovf_sticky <= 1'b0;
                r_count      <= '0;
            end else begin
                if (w_accept) r_count <= r_count + CNT_W'(1);
                if (r_prod_vld) begin
                    r_acc        <= w_acc_nxt;
                    r_ovf_sticky <= w_ovf_nxt;
                end
            end

            if (w_load_out) begin
                r_acc_out   <= r_acc;
                r_ovf_out   <= r_ovf_sticky;
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign Out_Valid = r_out_valid;
    assign Acc       = r_acc_out;
    assign Overflow  = r_ovf_out;
    assign Busy      = (r_state != ST_ACCUM) || (r_count != '0) ||
                       r_op_vld || r_prod_vld || r_sum_last;
endmodule

// File: tb/tb_wallace_mac_accumulator.sv
// Scoreboard bench for wallace_mac_accumulator: three instances (BLOCK_LEN 4/3/5, ACC_W 40/40/34)
// driven in turn; a negedge monitor builds expected block sums and checks every output handshake.

module tb_wallace_mac_accumulator;
    localparam int ND = 3;

    typedef struct packed {
        logic [63:0] acc;
        logic        ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [ND-1:0] in_valid, in_ready, out_valid, out_ready, ovf, busy;
    logic [15:0]   a [ND];
    logic [15:0]   b [ND];
    logic [39:0]   acc0, acc1;
    logic [33:0]   acc2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc_cyc = 0;

    exp_t        q0[$], q1[$], q2[$];
    logic [64:0] part     [ND];
    logic        part_ovf [ND];
    int          cnt      [ND];
    int          accepts  [ND];
    int          results  [ND];

    wallace_mac_accumulator #(.ACC_W(40), .BLOCK_LEN(4)) u_dut0 (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid[0]), .In_Ready(in_ready[0]),
        .A(a[0]), .B(b[0]), .Out_Valid(out_valid[0]), .Out_Ready(out_ready[0]),
        .Acc(acc0), .Overflow(ovf[0]), .Busy(busy[0])
    );
    wallace_mac_accumulator #(.ACC_W(40), .BLOCK_LEN(3)) u_dut1 (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid[1]), .In_Ready(in_ready[1]),
        .A(a[1]), .B(b[1]), .Out_Valid(out_valid[1]), .Out_Ready(out_ready[1]),
        .Acc(acc1), .Overflow(ovf[1]), .Busy(busy[1])
    );
    wallace_mac_accumulator #(.ACC_W(34), .BLOCK_LEN(5)) u_dut2 (
        .Clk(clk), .Rst(rst), .In_Valid(in_valid[2]), .In_Ready(in_ready[2]),
        .A(a[2]), .B(b[2]), .Out_Valid(out_valid[2]), .Out_Ready(out_ready[2]),
        .Acc(acc2), .Overflow(ovf[2]), .Busy(busy[2])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int blk_len(int i);
        case (i)
            0:       return 4;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int acc_w(int i);
        return (i == 2) ? 34 : 40;
    endfunction

    function automatic logic [63:0] acc_of(int i);
        case (i)
            0:       return 64'(acc0);
            1:       return 64'(acc1);
            default: return 64'(acc2);
        endcase
    endfunction

    function automatic int q_size(int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push_exp(int i, exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(int i, output exp_t e);
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endtask

    task automatic model_add(int i, logic [31:0] p);
        logic [64:0] s, mask;
        logic        cy;
        mask = (65'd1 << acc_w(i)) - 65'd1;
        s    = part[i] + 65'(p);
        cy   = s[acc_w(i)];
`ifdef SATURATE_EN
        part[i] = (cy || part_ovf[i]) ? mask : (s & mask);
`else
        part[i] = s & mask;
`endif
        part_ovf[i] = part_ovf[i] | cy;
    endtask

    // Monitor: inputs are driven just after posedge, so negedge sees what the next edge will act on.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            for (int i = 0; i < ND; i++) begin
                part[i]     = '0;
                part_ovf[i] = 1'b0;
                cnt[i]      = 0;
            end
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            for (int i = 0; i < ND; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    model_add(i, 32'(a[i]) * 32'(b[i]));
                    accepts[i]++;
                    cnt[i]++;
                    if (cnt[i] == blk_len(i)) begin
                        e.acc = part[i][63:0];
                        e.ovf = part_ovf[i];
                        push_exp(i, e);
                        part[i]     = '0;
                        part_ovf[i] = 1'b0;
                        cnt[i]      = 0;
                    end
                end
                if (out_valid[i] && out_ready[i]) begin
                    results[i]++;
                    chk($sformatf("out_expected_d%0d", i), 64'(q_size(i) > 0), 64'd1);
                    if (q_size(i) > 0) begin
                        pop_exp(i, e);
                        chk($sformatf("acc_d%0d", i), acc_of(i), e.acc);
                        chk($sformatf("ovf_d%0d", i), 64'(ovf[i]), 64'(e.ovf));
                    end
                end
            end
        end
    end

    task automatic send(int i, logic [15:0] aa, logic [15:0] bb);
        int t;
        in_valid[i] = 1'b1;
        a[i] = aa;
        b[i] = bb;
        t = 0;
        @(negedge clk);
        while (!in_ready[i] && t < 300) begin
            t++;
            @(negedge clk);
        end
        chk($sformatf("send_ready_d%0d", i), 64'(t < 300), 64'd1);
        last_acc_cyc = cyc + 1;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_out(int i, output int lat);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid[i] && t < 100) begin
            t++;
            @(negedge clk);
        end
        chk($sformatf("out_arrives_d%0d", i), 64'(t < 100), 64'd1);
        lat = cyc - last_acc_cyc;
    endtask

    initial begin
        int lat, seen, base_res, base_acc, t;
        bit done;

        for (int i = 0; i < ND; i++) begin
            a[i] = '0;
            b[i] = '0;
            accepts[i] = 0;
            results[i] = 0;
        end
        in_valid  = '0;
        out_ready = '0;
        rst       = 1'b1;

        // reset
        @(negedge clk);
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = '1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_acc0", 64'(acc0), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'h7);
        @(posedge clk);
        #1;

        // back-to-back block, consumer always ready
        send(0, 16'd3, 16'd5);
        send(0, 16'd7, 16'd11);
        send(0, 16'hFFFF, 16'hFFFF);
        send(0, 16'd0, 16'd1234);
        wait_out(0, lat);
        chk("t1_latency", 64'(lat), 64'd3);
        chk("t1_acc", 64'(acc0), 64'h00FFFE005D);
        chk("t1_ovf", 64'(ovf[0]), 64'd0);
        @(negedge clk);
        chk("t1_pulse_1cyc", 64'(out_valid[0]), 64'd0);
        @(posedge clk);
        #1;

        // consumer stalls for 10 cycles, then a fresh block must start from zero
        out_ready[0] = 1'b0;
        send(0, 16'd3, 16'd5);
        send(0, 16'd7, 16'd11);
        send(0, 16'hFFFF, 16'hFFFF);
        send(0, 16'd0, 16'd1234);
        wait_out(0, lat);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t2_hold_acc", 64'(acc0), 64'h00FFFE005D);
            chk("t2_hold_valid", 64'(out_valid[0]), 64'd1);
            chk("t2_hold_in_ready", 64'(in_ready[0]), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        for (int k = 0; k < 4; k++) send(0, 16'd1, 16'd1);
        wait_out(0, lat);
        chk("t2_next_acc", 64'(acc0), 64'd4);
        @(posedge clk);
        #1;

        // gapped In_Valid, BLOCK_LEN=3
        send(1, 16'd2, 16'd3);
        idle(2);
        send(1, 16'd4, 16'd5);
        idle(1);
        send(1, 16'd6, 16'd7);
        wait_out(1, lat);
        chk("t3_acc", 64'(acc1), 64'd68);
        chk("t3_accepts", 64'(accepts[1]), 64'd3);
        chk("t3_latency", 64'(lat), 64'd3);
        @(posedge clk);
        #1;

        // overflow with ACC_W=34
        for (int k = 0; k < 5; k++) send(2, 16'hFFFF, 16'hFFFF);
        wait_out(2, lat);
        chk("t4_ovf", 64'(ovf[2]), 64'd1);
`ifdef SATURATE_EN
        chk("t4_acc", 64'(acc2), 64'h3FFFFFFFF);
`else
        chk("t4_acc", 64'(acc2), 64'h0FFF60005);
`endif
        @(posedge clk);
        #1;

        // reset in the middle of a block
        send(0, 16'd100, 16'd200);
        send(0, 16'd300, 16'd400);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_in_ready_in_reset", 64'(in_ready[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", 64'(out_valid[0]), 64'd0);
        chk("t5_acc", 64'(acc0), 64'd0);
        chk("t5_ovf", 64'(ovf[0]), 64'd0);
        chk("t5_busy", 64'(busy[0]), 64'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            seen += int'(out_valid[0]);
        end
        chk("t5_no_output", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) send(0, 16'd1, 16'd2);
        wait_out(0, lat);
        chk("t5_fresh_acc", 64'(acc0), 64'd8);
        @(posedge clk);
        #1;

        // random blocks with input gaps and output stalls
        base_res = results[0];
        base_acc = accepts[0];
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    for (int j = 0; j < 4; j++) begin
                        send(0, 16'($urandom), 16'($urandom));
                        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                    end
                end
                t = 0;
                while (q0.size() != 0 && t < 200) begin
                    t++;
                    @(negedge clk);
                end
                chk("t6_drained", 64'(q0.size()), 64'd0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready[0] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_results", 64'(results[0] - base_res), 64'd1000);
        chk("t6_accepts", 64'(accepts[0] - base_acc), 64'd4000);
        chk("t6_idle_busy", 64'(busy[0]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
